// File: rtl/pushbutton_port.sv
// Four-button input port: two-flop synchroniser, per-bit debounce counter and
// sticky press bits that the uP clears by reading the port.
module pushbutton_port #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttons_raw,
    input  logic       latch_mode,
    input  logic       read_strobe,
    output logic [3:0] pushbuttons,
    output logic [3:0] debounced,
    output logic       press_pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("pushbutton_port: DEBOUNCE_CYCLES must be at least 1");
    end
    if ((DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_width
        $error("pushbutton_port: CNT_W too narrow for DEBOUNCE_CYCLES-1");
    end

    logic [3:0]            s1;
    logic [3:0]            s2;
    logic [3:0]            db;
    logic [3:0]            db_nxt;
    logic [3:0]            sticky;
    logic [3:0]            rise;
    logic [3:0][CNT_W-1:0] cnt;
    logic [3:0][CNT_W-1:0] cnt_nxt;

    // A bit only moves after s2 has disagreed with db for DEBOUNCE_CYCLES
    // consecutive edges; any agreement in between restarts the count.
    always_comb begin
        db_nxt  = db;
        cnt_nxt = cnt;
        for (int i = 0; i < 4; i++) begin
            if (s2[i] == db[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                db_nxt[i]  = s2[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    assign rise = db_nxt & ~db;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1     <= '0;
            s2     <= '0;
            db     <= '0;
            cnt    <= '0;
            sticky <= '0;
        end else begin
            s1     <= buttons_raw;
            s2     <= s1;
            db     <= db_nxt;
            cnt    <= cnt_nxt;
            // a press landing on the read edge survives so it is not lost
            sticky <= rise | (sticky & ~{4{read_strobe}});
        end
    end

    assign pushbuttons   = latch_mode ? sticky : db;
    assign debounced     = db;
    assign press_pending = |sticky;

endmodule

// File: tb/tb_pushbutton_port.sv
// Directed bench for pushbutton_port: stimulus queues expected outputs per
// clock edge, a monitor pops and compares them after each edge.
module tb_pushbutton_port;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] buttons_raw;
    logic       latch_mode;
    logic       read_strobe;
    logic [3:0] pushbuttons;
    logic [3:0] debounced;
    logic       press_pending;

    pushbutton_port #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .buttons_raw  (buttons_raw),
        .latch_mode   (latch_mode),
        .read_strobe  (read_strobe),
        .pushbuttons  (pushbuttons),
        .debounced    (debounced),
        .press_pending(press_pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         edge_n;
        logic [3:0] pb;
        logic [3:0] db;
        logic       pp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   base;

    always @(posedge clock) edge_cnt++;

    always @(posedge clock) begin
        if (edge_cnt > 1000) begin
            $display("FAIL watchdog: edge %0d exceeded budget 1000", edge_cnt);
            $fatal(1, "watchdog");
        end
    end

    // Monitor: compare every expectation scheduled for this edge
    always @(posedge clock) begin
        #2;
        while (q.size() != 0 && q[0].edge_n <= edge_cnt) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.edge_n < edge_cnt) begin
                errors++;
                $display("FAIL %s: check for edge %0d missed, now edge %0d", e.name, e.edge_n, edge_cnt);
            end else if (pushbuttons !== e.pb || debounced !== e.db || press_pending !== e.pp) begin
                errors++;
                $display("FAIL %s @edge %0d: got pb=%b db=%b pp=%b, expected pb=%b db=%b pp=%b",
                         e.name, edge_cnt, pushbuttons, debounced, press_pending, e.pb, e.db, e.pp);
            end
        end
    end

    task automatic push_exp(input int n, input logic [3:0] pb, input logic [3:0] db,
                            input logic pp, input string nm);
        exp_t e;
        e.edge_n = n; e.pb = pb; e.db = db; e.pp = pp; e.name = nm;
        q.push_back(e);
    endtask

    // Advance to the falling edge that follows posedge number n.
    task automatic go(input int n);
        do @(negedge clock); while (edge_cnt < n);
    endtask

    initial begin
        reset = 1'b0; buttons_raw = 4'hF; latch_mode = 1'b0; read_strobe = 1'b0;

        // reset held low with all buttons pressed
        push_exp(1, 4'h0, 4'h0, 1'b0, "rst_low_e1");
        push_exp(2, 4'h0, 4'h0, 1'b0, "rst_low_e2");
        go(3);
        reset = 1'b1; base = edge_cnt;
        push_exp(base + 5, 4'h0, 4'h0, 1'b0, "rst_rel_e5");
        push_exp(base + 6, 4'hF, 4'hF, 1'b1, "rst_rel_e6");

        // release all, read clears sticky
        go(base + 6);
        buttons_raw = 4'h0; read_strobe = 1'b1; base = edge_cnt;
        push_exp(base + 1, 4'hF, 4'hF, 1'b0, "read_clear");
        push_exp(base + 5, 4'hF, 4'hF, 1'b0, "release_e5");
        push_exp(base + 6, 4'h0, 4'h0, 1'b0, "release_e6");
        go(base + 1); read_strobe = 1'b0;

        // level-mode press of bits 0 and 2
        go(base + 6);
        buttons_raw = 4'b0101; base = edge_cnt;
        push_exp(base + 5, 4'h0, 4'h0, 1'b0, "lvl_press_e5");
        push_exp(base + 6, 4'h5, 4'h5, 1'b1, "lvl_press_e6");
        go(base + 6);
        buttons_raw = 4'h0; read_strobe = 1'b1; base = edge_cnt;
        push_exp(base + 1, 4'h5, 4'h5, 1'b0, "lvl_read");
        push_exp(base + 6, 4'h0, 4'h0, 1'b0, "lvl_release_e6");
        go(base + 1); read_strobe = 1'b0;

        // 3-cycle glitch on bit2 is rejected
        go(base + 6);
        buttons_raw = 4'b0100; base = edge_cnt;
        go(base + 3);
        buttons_raw = 4'h0;
        push_exp(base + 6, 4'h0, 4'h0, 1'b0, "glitch_e6");
        push_exp(base + 7, 4'h0, 4'h0, 1'b0, "glitch_e7");

        // 4-cycle pulse on bit2 gets through with full latency
        go(base + 7);
        buttons_raw = 4'b0100; base = edge_cnt;
        go(base + 4);
        buttons_raw = 4'h0;
        push_exp(base + 5,  4'h0, 4'h0, 1'b0, "pulse4_e5");
        push_exp(base + 6,  4'h4, 4'h4, 1'b1, "pulse4_e6");
        push_exp(base + 9,  4'h4, 4'h4, 1'b1, "pulse4_e9");
        push_exp(base + 10, 4'h0, 4'h0, 1'b1, "pulse4_fall");

        // latched mode: press/release bit0, then read
        go(base + 10);
        read_strobe = 1'b1; latch_mode = 1'b1; base = edge_cnt;
        push_exp(base + 1, 4'h0, 4'h0, 1'b0, "lat_clear");
        go(base + 1);
        read_strobe = 1'b0; buttons_raw = 4'b0001; base = edge_cnt;
        push_exp(base + 5, 4'h0, 4'h0, 1'b0, "lat_press_e5");
        push_exp(base + 6, 4'h1, 4'h1, 1'b1, "lat_press_e6");
        go(base + 6);
        buttons_raw = 4'h0; base = edge_cnt;
        push_exp(base + 5, 4'h1, 4'h1, 1'b1, "lat_rel_e5");
        push_exp(base + 6, 4'h1, 4'h0, 1'b1, "lat_hold");
        go(base + 6);
        read_strobe = 1'b1; base = edge_cnt;
        push_exp(base + 1, 4'h0, 4'h0, 1'b0, "lat_read");
        go(base + 1);

        // set-over-clear: bit1 sticky, bit3 rises on the read edge
        read_strobe = 1'b0; buttons_raw = 4'b0010; base = edge_cnt;
        push_exp(base + 6, 4'h2, 4'h2, 1'b1, "soc_bit1");
        go(base + 6);
        buttons_raw = 4'b1010; base = edge_cnt;
        push_exp(base + 5, 4'h2, 4'h2, 1'b1, "soc_e5");
        go(base + 5);
        read_strobe = 1'b1;
        push_exp(base + 6, 4'h8, 4'hA, 1'b1, "set_over_clear");
        go(base + 6);
        read_strobe = 1'b0;
        push_exp(base + 7, 4'h8, 4'hA, 1'b1, "soc_hold");
        go(base + 7);
        buttons_raw = 4'h0; base = edge_cnt;
        push_exp(base + 6, 4'h8, 4'h0, 1'b1, "release_keeps_sticky");
        go(base + 6);

        // reset in the middle of a bit1 debounce, with sticky[3] still set
        latch_mode = 1'b0; buttons_raw = 4'b0010; base = edge_cnt;
        push_exp(base + 1, 4'h0, 4'h0, 1'b1, "mode_switch");
        go(base + 3);
        reset = 1'b0;
        push_exp(base + 4, 4'h0, 4'h0, 1'b0, "rst_mid");
        go(base + 5);
        reset = 1'b1; base = edge_cnt;
        push_exp(base + 5, 4'h0, 4'h0, 1'b0, "rst_mid_e5");
        push_exp(base + 6, 4'h2, 4'h2, 1'b1, "rst_mid_e6");
        go(base + 8);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
